// File: rtl/relu_forward_if.sv
// Memory handle shared by the FPU ops: one port into a tensor region.
// Handshake: the requester raises its strobe (r_en or w_en) together with
// avail and holds ptr/data_store stable until it samples done high; it drops
// the strobe in the cycle done is seen. done is a one-cycle pulse from memory.
interface mem_handle;
    logic        r_en;
    logic        w_en;
    logic        avail;
    logic [31:0] ptr;
    logic [31:0] data_store;
    logic        write_through;
    logic [31:0] region_begin;
    logic [31:0] region_end;
    logic [31:0] data_load;
    logic        done;

    modport master (
        output r_en, w_en, avail, ptr, data_store, write_through,
        input  region_begin, region_end, data_load, done
    );

    modport slave (
        input  r_en, w_en, avail, ptr, data_store, write_through,
        output region_begin, region_end, data_load, done
    );
endinterface

// File: rtl/relu_forward.sv
// Forward ReLU: copies the tensor header of `a` to `d` unchanged, then streams
// every element through y = x[31] ? +0.0 : x. One memory access at a time.
module relu_forward #(
    parameter int MAX_NDIM = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    mem_handle.master   a,
    mem_handle.master   d,
    input  logic        go,
    output logic        done,
    output logic [31:0] elems,
    output logic [2:0]  state
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_HDR_RD = 3'd2;
    localparam logic [2:0] S_HDR_WR = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_RD     = 3'd5;
    localparam logic [2:0] S_WR     = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic        a_act;
    logic [31:0] a_ptr;
    logic        d_act;
    logic [31:0] d_ptr;
    logic [31:0] d_data;
    logic        d_wt;
    logic [31:0] ndim_q;
    logic [31:0] hdr_cnt;
    logic [31:0] hdr_len;
    logic        d_last;

    // Sign-bit gate: every negative encoding (incl. -0.0, -NaN) becomes +0.0.
    function automatic logic [31:0] relu(input logic [31:0] x);
        return x[31] ? 32'h0000_0000 : x;
    endfunction

    // Header length is 1 + ndim, with ndim clamped to MAX_NDIM.
    always_comb begin
        hdr_len = 32'd0;
        if (ndim_q > 32'(MAX_NDIM))
            hdr_len = 32'(MAX_NDIM) + 32'd1;
        else
            hdr_len = ndim_q + 32'd1;
    end

    // The write about to be issued lands on the last word of the region.
    assign d_last = (d_ptr == d.region_end - 32'd1);

    // Main sequencer: state, pointers, strobes and the element counter.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= S_WAIT;
            a_act   <= 1'b0;
            a_ptr   <= 32'd0;
            d_act   <= 1'b0;
            d_ptr   <= 32'd0;
            d_data  <= 32'd0;
            d_wt    <= 1'b0;
            ndim_q  <= 32'd0;
            hdr_cnt <= 32'd0;
            elems   <= 32'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (go)
                        state <= S_START;
                end
                S_START: begin
                    a_ptr   <= a.region_begin;
                    d_ptr   <= d.region_begin;
                    elems   <= 32'd0;
                    hdr_cnt <= 32'd0;
                    a_act   <= 1'b1;
                    state   <= S_HDR_RD;
                end
                S_HDR_RD: begin
                    if (a.done) begin
                        a_act  <= 1'b0;
                        d_data <= a.data_load;
                        if (hdr_cnt == 32'd0)
                            ndim_q <= a.data_load;
                        d_act  <= 1'b1;
                        d_wt   <= d_last;
                        state  <= S_HDR_WR;
                    end
                end
                S_HDR_WR: begin
                    if (d.done) begin
                        d_act   <= 1'b0;
                        d_wt    <= 1'b0;
                        a_ptr   <= a_ptr + 32'd1;
                        d_ptr   <= d_ptr + 32'd1;
                        hdr_cnt <= hdr_cnt + 32'd1;
                        if (hdr_cnt + 32'd1 == hdr_len) begin
                            state <= S_CHECK;
                        end else begin
                            a_act <= 1'b1;
                            state <= S_HDR_RD;
                        end
                    end
                end
                S_CHECK: begin
                    if (d_ptr == d.region_end) begin
                        state <= S_DONE;
                    end else begin
                        a_act <= 1'b1;
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    if (a.done) begin
                        a_act  <= 1'b0;
                        a_ptr  <= a_ptr + 32'd1;
                        d_data <= relu(a.data_load);
                        d_act  <= 1'b1;
                        d_wt   <= d_last;
                        state  <= S_WR;
                    end
                end
                S_WR: begin
                    if (d.done) begin
                        d_act <= 1'b0;
                        d_wt  <= 1'b0;
                        d_ptr <= d_ptr + 32'd1;
                        elems <= elems + 32'd1;
                        state <= S_CHECK;
                    end
                end
                S_DONE: begin
                    if (!go)
                        state <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign done = (state == S_DONE);

    assign a.r_en          = a_act;
    assign a.avail         = a_act;
    assign a.ptr           = a_ptr;
    assign a.w_en          = 1'b0;
    assign a.data_store    = 32'd0;
    assign a.write_through = 1'b0;

    assign d.r_en          = 1'b0;
    assign d.w_en          = d_act;
    assign d.avail         = d_act;
    assign d.ptr           = d_ptr;
    assign d.data_store    = d_data;
    assign d.write_through = d_wt;

endmodule

// File: tb/tb_relu_forward.sv
// Bench for relu_forward: two handle memories with configurable latency,
// directed tensors with hand-written expected outputs, and a write monitor.
module tb_relu_forward;

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_WR   = 3'd6;

    logic        clk;
    logic        rst_l;
    logic        go;
    logic        done;
    logic [31:0] elems;
    logic [2:0]  state;

    mem_handle a_if ();
    mem_handle d_if ();

    relu_forward #(.MAX_NDIM(4)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .a     (a_if),
        .d     (d_if),
        .go    (go),
        .done  (done),
        .elems (elems),
        .state (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared bench state ----------------
    int          checks;
    int          failures;
    logic [64:0] exp_q[$];
    logic [31:0] mem_a[0:255];
    logic [31:0] src[0:127];
    logic [31:0] expd[0:127];
    bit          rnd_lat;
    int          reads;
    int          overlap_cnt;
    int          unstable_cnt;

    function automatic logic [31:0] relu_ref(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    function automatic int pick_lat();
        return rnd_lat ? int'($urandom_range(1, 7)) : 1;
    endfunction

    // ---------------- memory responders ----------------
    bit a_busy, d_busy;
    int a_cnt, d_cnt, a_lat, d_lat;

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            a_if.done <= 1'b0; a_if.data_load <= 32'd0; a_busy <= 1'b0; a_cnt <= 0;
        end else if (a_if.done) begin
            a_if.done <= 1'b0;
        end else if (a_busy) begin
            if (a_cnt <= 1) begin
                a_if.done <= 1'b1; a_busy <= 1'b0;
                a_if.data_load <= mem_a[a_if.ptr[7:0]];
            end else a_cnt <= a_cnt - 1;
        end else if (a_if.r_en) begin
            a_lat = pick_lat();
            if (a_lat == 1) begin
                a_if.done <= 1'b1; a_if.data_load <= mem_a[a_if.ptr[7:0]];
            end else begin
                a_busy <= 1'b1; a_cnt <= a_lat - 1;
            end
        end
    end

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            d_if.done <= 1'b0; d_if.data_load <= 32'd0; d_busy <= 1'b0; d_cnt <= 0;
        end else if (d_if.done) begin
            d_if.done <= 1'b0;
        end else if (d_busy) begin
            if (d_cnt <= 1) begin
                d_if.done <= 1'b1; d_busy <= 1'b0;
            end else d_cnt <= d_cnt - 1;
        end else if (d_if.w_en) begin
            d_lat = pick_lat();
            if (d_lat == 1) d_if.done <= 1'b1;
            else begin
                d_busy <= 1'b1; d_cnt <= d_lat - 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        a_was, d_was;
    logic [31:0] a_ptr0, d_ptr0, d_data0;
    logic [64:0] got, want;

    always @(negedge clk) begin
        if (!rst_l) begin
            a_was = 1'b0; d_was = 1'b0;
        end else begin
            if (a_if.r_en && d_if.w_en) overlap_cnt++;
            if (a_if.r_en && !a_was) a_ptr0 = a_if.ptr;
            else if (a_if.r_en && a_if.ptr !== a_ptr0) unstable_cnt++;
            if (d_if.w_en && !d_was) begin
                d_ptr0 = d_if.ptr; d_data0 = d_if.data_store;
            end else if (d_if.w_en && (d_if.ptr !== d_ptr0 || d_if.data_store !== d_data0))
                unstable_cnt++;
            a_was = a_if.r_en;
            d_was = d_if.w_en;
            if (a_if.r_en && a_if.done) reads++;
            if (d_if.w_en && d_if.done) begin
                got = {d_if.write_through, d_if.ptr, d_if.data_store};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got wt/ptr/data=%h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL d_write got wt/ptr/data=%h expected %h", got, want);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic setup(input int a_base, input int d_base, input int len);
        for (int i = 0; i < len; i++) begin
            mem_a[a_base + i] = src[i];
            exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, 32'(d_base + i), expd[i]});
        end
        a_if.region_begin = 32'(a_base);
        a_if.region_end   = 32'(a_base + len);
        d_if.region_begin = 32'(d_base);
        d_if.region_end   = 32'(d_base + len);
    endtask

    task automatic run_op(input string name, input int exp_cyc, input int exp_elems,
                          input int exp_reads, input int hold);
        int cyc;
        reads = 0; overlap_cnt = 0; unstable_cnt = 0;
        @(negedge clk);
        go = 1'b1;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_done_reached"}, 65'(done), 65'd1);
        if (exp_cyc >= 0) chk({name, "_go_to_done_cycles"}, 65'(cyc), 65'(exp_cyc));
        chk({name, "_elems"}, 65'(elems), 65'(exp_elems));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_done_held"}, 65'(done), 65'd1);
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;
        chk({name, "_done_fall"}, 65'(done), 65'd0);
        chk({name, "_state_wait"}, 65'(state), 65'(S_WAIT));
        chk({name, "_all_writes_seen"}, 65'(exp_q.size()), 65'd0);
        chk({name, "_reads"}, 65'(reads), 65'(exp_reads));
        chk({name, "_no_overlap"}, 65'(overlap_cnt), 65'd0);
        chk({name, "_ptr_stable"}, 65'(unstable_cnt), 65'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        checks = 0; failures = 0; rnd_lat = 1'b0;
        reads = 0; overlap_cnt = 0; unstable_cnt = 0;
        go = 1'b0; rst_l = 1'b0;
        a_if.region_begin = 0; a_if.region_end = 0;
        d_if.region_begin = 0; d_if.region_end = 0;
        for (int i = 0; i < 256; i++) mem_a[i] = 32'd0;
        #2;
        chk("reset_state", 65'(state), 65'(S_WAIT));
        chk("reset_done", 65'(done), 65'd0);
        chk("reset_elems", 65'(elems), 65'd0);
        chk("reset_a_fields", 65'({a_if.r_en, a_if.w_en, a_if.avail, a_if.ptr, a_if.data_store}), 65'd0);
        chk("reset_d_fields", 65'({d_if.r_en, d_if.w_en, d_if.avail, d_if.write_through, d_if.ptr}), 65'd0);
        chk("reset_d_data", 65'(d_if.data_store), 65'd0);
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        // 1-D: negatives, -0.0 and +NaN; go held 10 cycles past done
        src[0] = 1; src[1] = 4; src[2] = 32'h4040_0000; src[3] = 32'hC000_0000;
        src[4] = 32'h8000_0000; src[5] = 32'h7FC0_0000;
        expd[0] = 1; expd[1] = 4; expd[2] = 32'h4040_0000; expd[3] = 32'h0;
        expd[4] = 32'h0; expd[5] = 32'h7FC0_0000;
        setup(16, 100, 6);
        run_op("t1d", 31, 4, 6, 10);

        // 2-D all-positive incl. +Inf, denormal, +NaN, +0: bit-identical copy
        src[0] = 2; src[1] = 2; src[2] = 3;
        src[3] = 32'h3F80_0000; src[4] = 32'h4000_0000; src[5] = 32'h7F80_0000;
        src[6] = 32'h0000_0001; src[7] = 32'h7FFF_FFFF; src[8] = 32'h0000_0000;
        for (int i = 0; i < 9; i++) expd[i] = src[i];
        setup(32, 110, 9);
        run_op("t2d", 45, 6, 9, 0);

        // empty tensor: header only, write_through on word 1
        src[0] = 1; src[1] = 0;
        expd[0] = 1; expd[1] = 0;
        setup(48, 120, 2);
        run_op("tempty", 11, 0, 2, 0);

        // ndim above MAX_NDIM clamps the header to 5 words
        src[0] = 6; src[1] = 1; src[2] = 2; src[3] = 3; src[4] = 4;
        src[5] = 32'hBF80_0000; src[6] = 32'h0080_0000;
        expd[0] = 6; expd[1] = 1; expd[2] = 2; expd[3] = 3; expd[4] = 4;
        expd[5] = 32'h0; expd[6] = 32'h0080_0000;
        setup(56, 130, 7);
        run_op("tclamp", 33, 2, 7, 0);

        // random latency on both handles, 64 random values
        rnd_lat = 1'b1;
        src[0] = 1; src[1] = 64; expd[0] = 1; expd[1] = 64;
        for (int i = 2; i < 66; i++) begin
            src[i] = $urandom;
            expd[i] = relu_ref(src[i]);
        end
        setup(140, 0, 66);
        run_op("trand", -1, 64, 66, 0);
        rnd_lat = 1'b0;

        // reset during the third element's write, then a clean rerun
        src[0] = 2; src[1] = 2; src[2] = 3;
        src[3] = 32'h3F80_0000; src[4] = 32'hBF80_0000; src[5] = 32'h4120_0000;
        src[6] = 32'h8000_0001; src[7] = 32'hFFC0_0000; src[8] = 32'h0000_0010;
        expd[0] = 2; expd[1] = 2; expd[2] = 3;
        expd[3] = 32'h3F80_0000; expd[4] = 32'h0; expd[5] = 32'h4120_0000;
        expd[6] = 32'h0; expd[7] = 32'h0; expd[8] = 32'h0000_0010;
        setup(80, 200, 9);
        @(negedge clk);
        go = 1'b1;
        cnt = 0;
        while (!(state == S_WR && elems == 32'd2) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("trst_reached_third_wr", 65'(state == S_WR && elems == 32'd2), 65'd1);
        rst_l = 1'b0;
        go = 1'b0;
        #1;
        chk("trst_strobes_zero", 65'({a_if.r_en, a_if.avail, d_if.w_en, d_if.avail, d_if.write_through}), 65'd0);
        chk("trst_state", 65'(state), 65'(S_WAIT));
        chk("trst_done", 65'(done), 65'd0);
        chk("trst_elems", 65'(elems), 65'd0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        setup(80, 200, 9);
        run_op("trerun", 45, 6, 9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_forward.md
# relu_forward

Forward ReLU stage of the FPU. Streams an fp32 tensor from memory handle `a` to memory handle `d`, replacing each negative element with +0.0. Its output region is the activation tensor that the backward ReLU stage later reads back for sign checks. It shares the `go`/`done` protocol and `mem_handle` usage of the other FPU ops.

## Interface
- Parameters:
  - `MAX_NDIM`, default 4: maximum number of dimension words in a tensor header; larger `ndim` values are clamped to this.
- Ports:
  - `clk`  input  1  core clock.
  - `rst_l`  input  1  asynchronous, active-low reset.
  - `a`  mem_handle  —  source tensor; this block drives `r_en`, `avail`, `ptr`; `w_en`=0, `data_store`=0.
  - `d`  mem_handle  —  destination tensor; this block drives `w_en`, `avail`, `ptr`, `data_store`, `write_through`; `r_en`=0.
  - `go`  input  1  start request, level; held high until `done` is observed.
  - `done`  output  1  high exactly while the FSM is in DONE.
  - `elems`  output  32  count of element words written (excludes header); valid in DONE.

## Operation
- Tensor layout: word 0 = `ndim`, words 1..`ndim` = dimension sizes, then elements up to `region_end` (exclusive). Header length H = 1 + min(`ndim`, `MAX_NDIM`).
- States:
  - WAIT: `go` → START.
  - START: load `a.ptr`←`a.region_begin`, `d.ptr`←`d.region_begin`, `elems`←0, then → HDR_RD.
  - HDR_RD: read `a`, latch the word, then → HDR_WR.
  - HDR_WR: write the latched word unchanged to `d`; advance both pointers. After H header words → CHECK, else → HDR_RD. `ndim` is latched from word 0.
  - CHECK: `d.ptr == d.region_end` → DONE, else → RD.
  - RD: read `a`, latch x, `a.ptr`+1, then → WR.
  - WR: write y to `d`, `d.ptr`+1, `elems`+1, then → CHECK.
  - DONE: `go` low → WAIT.
- ReLU function: y = x[31] ? 32'h0000_0000 : x.
  - -0.0, negative denormals and negative-signed NaN all map to +0.0.
  - Positive NaN and +Inf pass through bit-exact.
  - No rounding; the transform is purely sign-bit gated.
- Memory access handshake: assert the strobe (`r_en`/`w_en`) together with `avail`, and hold `ptr`/`data_store` stable until `done` is sampled high. Deassert both in the cycle `done` is seen. `a` and `d` are never active in the same cycle.
- `d.write_through`=1 accompanies the write whose address is `d.region_end-1`, whether that is a header or an element write; it is 0 otherwise.
- Empty tensor (`region_end` = `region_begin` + H): header is copied, CHECK → DONE, `elems`=0.
- `go` dropping mid-operation is ignored; the op runs to DONE and then returns to WAIT in the next cycle.

## Timing
- Reset (async, `rst_l` low): state=WAIT, `done`=0, `elems`=0.
  - All driven handle fields = 0: `r_en`, `w_en`, `avail`, `ptr`, `data_store`, `write_through`.
  - Reset mid-transfer aborts the transfer immediately; no write completes after reset.
- Latency from `go` to the first `a.r_en` is 2 cycles (WAIT→START→HDR_RD).
- Each access occupies its state until the handle's `done`, plus one cycle for the state change.
  - With a 1-cycle memory, each word costs 4 cycles (2 states × 2 cycles) plus 1 CHECK cycle per element.
  - Total ≈ 2 + 4H + 5N + 1 cycles for N elements.
- `done` rises the cycle after CHECK sees `d.ptr == d.region_end`. It stays high while `go`=1 and falls one cycle after `go` falls.
- `elems` updates in the cycle the WR access completes.

## Test plan
- 1-D tensor [1, 4, 3.0, -2.0, -0.0, 0x7FC00000], 1-cycle memory:
  - `d` = [1, 4, 0x40400000, 0, 0, 0x7FC00000].
  - `elems`=4.
  - `write_through` only on the last word.
  - `done` asserted 2+4·2+5·4+1 cycles after `go`.
- 2-D header [2, 2, 3] plus 6 all-positive elements: output is bit-identical to input, `elems`=6.
- Empty tensor [1, 0] with `region_end`=begin+2: header copied, `write_through` on the word-1 write, `elems`=0, no element accesses.
- Randomised memory latency 1–7 cycles on both handles, 64 random fp32 values:
  - each output equals ReLU(x).
  - `a`/`d` strobes are never high together.
  - `ptr` is stable while a strobe is high.
- Hold `go` high 10 cycles past `done`, then drop it: `done` stays high for those cycles, falls 1 cycle after `go` falls, and the FSM is in WAIT.
- Pulse `rst_l` low during the third element's WR: all strobes are 0 immediately, state is WAIT, and a subsequent `go` reprocesses the whole tensor correctly.
